// File: rtl/nic_dma_pkg.sv
// nic_dma_pkg: shared FSM state type and NIC register map for the receive DMA controller.
package nic_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POLL  = 2'd1,
        FETCH = 2'd2,
        WRITE = 2'd3
    } dma_state_e;

    localparam logic [1:0] NIC_IN_BUF     = 2'b00;
    localparam logic [1:0] NIC_IN_STAT    = 2'b01;
    localparam int         STAT_VALID_BIT = 0;

endpackage

// File: rtl/nic_dma_ptrs.sv
// nic_dma_ptrs: mailbox write/read pointers and occupancy counter.
// Push and pop in the same cycle leave the count unchanged; pop on an empty mailbox is ignored.
module nic_dma_ptrs #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W:0]   count,
    output logic             full
);

    logic pop_ok;

    assign pop_ok = pop && (count != '0);
    assign full   = (count == (PTR_W+1)'(DEPTH));

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/nic_dma_ctrl.sv
// nic_dma_ctrl: cycle-stealing NIC receive DMA into a circular DMEM mailbox; CPU always wins both ports.
// Optional NIC_DMA_DROP_CNT_EN: keep polling when full, discard fetched packets and count them in drop_count.
module nic_dma_ctrl
    import nic_dma_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hC0,
    parameter int         DEPTH     = 16,
    parameter int         PTR_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dma_en,
    input  logic             dma_pop,
    input  logic             cpu_memEn,
    input  logic             cpu_memWrEn,
    input  logic [7:0]       cpu_addr,
    input  logic [63:0]      cpu_d_out,
    output logic             mem_memEn,
    output logic             mem_memWrEn,
    output logic [7:0]       mem_addr,
    output logic [63:0]      mem_d_out,
    input  logic             cpu_nicEn,
    input  logic             cpu_nicWrEn,
    input  logic [1:0]       cpu_addr_nic,
    input  logic [63:0]      cpu_din_nic,
    output logic             nic_nicEn,
    output logic             nic_nicWrEn,
    output logic [1:0]       nic_addr,
    output logic [63:0]      nic_din,
    input  logic [63:0]      nic_dout,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W:0]   pkt_count,
    output logic             dma_busy
`ifdef NIC_DMA_DROP_CNT_EN
    ,
    output logic [15:0]      drop_count
`endif
);

    dma_state_e  state, next_state;
    logic [63:0] data_q;
    logic        full, push, latch, drop;
    logic        dma_nic, dma_mem;
    logic [1:0]  dma_nic_addr;

    nic_dma_ptrs #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ptrs (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (dma_pop),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (pkt_count),
        .full   (full)
    );

    always_comb begin
        next_state   = state;
        dma_nic      = 1'b0;
        dma_nic_addr = NIC_IN_STAT;
        dma_mem      = 1'b0;
        latch        = 1'b0;
        push         = 1'b0;
        drop         = 1'b0;
        case (state)
            IDLE: begin
`ifdef NIC_DMA_DROP_CNT_EN
                if (dma_en)
`else
                if (dma_en && !full)
`endif
                    next_state = POLL;
            end
            POLL: begin
                if (!cpu_nicEn) begin
                    dma_nic    = 1'b1;
                    next_state = nic_dout[STAT_VALID_BIT] ? FETCH : IDLE;
                end
            end
            FETCH: begin
                if (!cpu_nicEn) begin
                    dma_nic      = 1'b1;
                    dma_nic_addr = NIC_IN_BUF;
                    latch        = 1'b1;
                    next_state   = WRITE;
`ifdef NIC_DMA_DROP_CNT_EN
                    if (full) begin
                        drop       = 1'b1;
                        next_state = IDLE;
                    end
`endif
                end
            end
            WRITE: begin
                if (!cpu_memEn) begin
                    dma_mem    = 1'b1;
                    push       = 1'b1;
                    next_state = IDLE;
                end
            end
        endcase
    end

    // Pure combinational muxing keeps CPU pass-through alive while reset is held
    assign mem_memEn   = cpu_memEn | dma_mem;
    assign mem_memWrEn = cpu_memEn ? cpu_memWrEn : dma_mem;
    assign mem_addr    = cpu_memEn ? cpu_addr : BASE_ADDR + 8'(wr_ptr);
    assign mem_d_out   = cpu_memEn ? cpu_d_out : data_q;
    assign nic_nicEn   = cpu_nicEn | dma_nic;
    assign nic_nicWrEn = cpu_nicEn & cpu_nicWrEn;
    assign nic_addr    = cpu_nicEn ? cpu_addr_nic : dma_nic_addr;
    assign nic_din     = cpu_nicEn ? cpu_din_nic : '0;
    assign dma_busy    = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            data_q <= '0;
        end else begin
            state <= next_state;
            if (latch)
                data_q <= nic_dout;
        end
    end

`ifdef NIC_DMA_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_nic_dma_ctrl.sv
// tb_nic_dma_ctrl: directed latency/full/reset scenarios plus randomized CPU contention,
// checked against a packet-queue model of the NIC and the mailbox.
module tb_nic_dma_ctrl;
    import nic_dma_pkg::*;

    localparam logic [7:0] BASE  = 8'hC0;
    localparam int         DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dma_en = 1'b0, dma_pop = 1'b0;
    logic        cpu_memEn = 1'b0, cpu_memWrEn = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [63:0] cpu_d_out = '0;
    logic        mem_memEn, mem_memWrEn;
    logic [7:0]  mem_addr;
    logic [63:0] mem_d_out;
    logic        cpu_nicEn = 1'b0, cpu_nicWrEn = 1'b0;
    logic [1:0]  cpu_addr_nic = '0;
    logic [63:0] cpu_din_nic = '0;
    logic        nic_nicEn, nic_nicWrEn;
    logic [1:0]  nic_addr;
    logic [63:0] nic_din, nic_dout;
    logic [3:0]  wr_ptr, rd_ptr;
    logic [4:0]  pkt_count;
    logic        dma_busy;
`ifdef NIC_DMA_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    always #5 clk = ~clk;

    nic_dma_ctrl dut (
        .clk(clk), .reset(reset), .dma_en(dma_en), .dma_pop(dma_pop),
        .cpu_memEn(cpu_memEn), .cpu_memWrEn(cpu_memWrEn), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out),
        .mem_memEn(mem_memEn), .mem_memWrEn(mem_memWrEn), .mem_addr(mem_addr), .mem_d_out(mem_d_out),
        .cpu_nicEn(cpu_nicEn), .cpu_nicWrEn(cpu_nicWrEn), .cpu_addr_nic(cpu_addr_nic), .cpu_din_nic(cpu_din_nic),
        .nic_nicEn(nic_nicEn), .nic_nicWrEn(nic_nicWrEn), .nic_addr(nic_addr), .nic_din(nic_din),
        .nic_dout(nic_dout), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .pkt_count(pkt_count), .dma_busy(dma_busy)
`ifdef NIC_DMA_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    // NIC: a queue of arrived packets; status shows non-empty, buffer shows the head
    logic [63:0] nic_q[$];
    logic [63:0] pend[$];
    logic        nic_valid = 1'b0;
    logic [63:0] nic_head = '0;
    assign nic_dout = (nic_addr == NIC_IN_STAT) ? {63'b0, nic_valid} :
                      (nic_addr == NIC_IN_BUF)  ? nic_head : 64'h5A5A_0000_1234_5678;

    int  n_tests = 0, n_fail = 0;
    int  m_count = 0, m_wr = 0, m_rd = 0, m_total = 0, m_drop = 0, gen_total = 0;
    int  pop_pct = 20, lat;
    bit  nic_pop_pend = 0, wr_seen = 0, rnd = 0, done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nic_sync();
        nic_valid = (nic_q.size() != 0);
        nic_head  = nic_valid ? nic_q[0] : 64'h0;
    endtask

    task automatic add_pkt(input logic [63:0] p);
        nic_q.push_back(p);
        gen_total++;
        nic_sync();
    endtask

    task automatic model_clear();
        m_count = 0; m_wr = 0; m_rd = 0; m_total = 0; m_drop = 0; gen_total = 0;
        pend.delete();
        nic_q.delete();
        nic_pop_pend = 0;
        nic_sync();
    endtask

    task automatic observe();
        bit buf_read, dma_wr, pop_ok;
        chk("wr_ptr", wr_ptr, m_wr);
        chk("rd_ptr", rd_ptr, m_rd);
        chk("pkt_count", pkt_count, m_count);
`ifdef NIC_DMA_DROP_CNT_EN
        chk("drop_count", drop_count, m_drop);
`endif
        if (cpu_memEn) begin
            chk("mem_pass", {mem_memEn, mem_memWrEn, mem_addr}, {1'b1, cpu_memWrEn, cpu_addr});
            chk("mem_pass_data", mem_d_out, cpu_d_out);
        end
        if (cpu_nicEn) begin
            chk("nic_pass", {nic_nicEn, nic_nicWrEn, nic_addr}, {1'b1, cpu_nicWrEn, cpu_addr_nic});
            chk("nic_pass_data", nic_din, cpu_din_nic);
        end else if (nic_nicEn)
            chk("dma_nic_read_only", nic_nicWrEn, 0);
        buf_read = !cpu_nicEn && nic_nicEn && nic_addr == NIC_IN_BUF;
        dma_wr   = !cpu_memEn && mem_memEn;
        pop_ok   = dma_pop && m_count > 0;
        if (buf_read) begin
            chk("fetch_when_valid", nic_valid, 1);
            nic_pop_pend = 1;
`ifdef NIC_DMA_DROP_CNT_EN
            if (m_count == DEPTH) m_drop = (m_drop < 16'hFFFF) ? m_drop + 1 : m_drop;
            else pend.push_back(nic_head);
`else
            chk("fetch_not_full", m_count < DEPTH, 1);
            pend.push_back(nic_head);
`endif
        end
        if (dma_wr) begin
            wr_seen = 1;
            chk("dma_wr_en", mem_memWrEn, 1);
            chk("dma_wr_addr", mem_addr, BASE + 8'(m_wr));
            chk("dma_wr_has_pkt", pend.size() != 0, 1);
            if (pend.size() != 0) chk("dma_wr_data", mem_d_out, pend.pop_front());
            m_wr = (m_wr + 1) % DEPTH;
            m_total++;
        end
        if (pop_ok) m_rd = (m_rd + 1) % DEPTH;
        m_count = m_count + int'(dma_wr) - int'(pop_ok);
        if (dma_wr) chk("no_overflow", m_count <= DEPTH, 1);
    endtask

    task automatic drive_random();
        cpu_memEn    = ($urandom % 100) < 30;
        cpu_memWrEn  = 1'($urandom);
        cpu_addr     = 8'($urandom);
        cpu_d_out    = {$urandom, $urandom};
        cpu_nicEn    = ($urandom % 100) < 20;
        cpu_nicWrEn  = 1'($urandom);
        cpu_addr_nic = {1'b1, 1'($urandom)};
        cpu_din_nic  = {$urandom, $urandom};
        dma_en       = ($urandom % 100) < 90;
        dma_pop      = ($urandom % 100) < pop_pct;
        if (nic_q.size() < 4 && $urandom % 3 == 0) begin
            nic_q.push_back({$urandom, $urandom});
            gen_total++;
        end
    endtask

    // One clock: check and model at the falling edge, then update NIC and stimulus just after the rising edge
    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        if (nic_pop_pend) begin
            void'(nic_q.pop_front());
            nic_pop_pend = 0;
        end
        if (rnd) drive_random();
        nic_sync();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_clear();
    endtask

    task automatic settle_idle();
        dma_en = 1'b0;
        repeat (4) cycle();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_rd_ptr", rd_ptr, 0);
        chk("rst_count", pkt_count, 0);
        chk("rst_busy", dma_busy, 0);
        cpu_memEn = 1'b1; cpu_addr = 8'h12; cpu_memWrEn = 1'b1;
        #1;
        chk("rst_mem_pass", {mem_memEn, mem_memWrEn, mem_addr}, {1'b1, 1'b1, 8'h12});
        cpu_memEn = 1'b0; cpu_memWrEn = 1'b0;
        reset = 1'b1;
        model_clear();

        // single packet on idle ports
        dma_en = 1'b1;
        add_pkt(64'hDEAD_BEEF_0000_0001);
        wr_seen = 0; lat = 0;
        for (int i = 0; i < 20 && !wr_seen; i++) begin
            cycle();
            if (!wr_seen) lat++;
        end
        chk("lat_idle", lat, 3);
        cycle();
        chk("t1_wr_ptr", wr_ptr, 1);
        chk("t1_count", pkt_count, 1);

        // CPU holds DMEM for 4 cycles spanning WRITE
        settle_idle();
        dma_en = 1'b1;
        add_pkt(64'h1111_2222_3333_4444);
        repeat (3) cycle();
        cpu_memEn = 1'b1; cpu_memWrEn = 1'b1; cpu_addr = 8'h33; cpu_d_out = 64'hCAFE_F00D_0000_0033;
        wr_seen = 0; lat = 3;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (wr_seen) break;
            lat++;
            if (lat == 7) cpu_memEn = 1'b0;
        end
        chk("lat_contention", lat, 7);
        chk("t2_count_model", m_count, 2);

        // asynchronous reset while a write is pending
        settle_idle();
        dma_en = 1'b1;
        add_pkt(64'h7777_8888_9999_AAAA);
        repeat (3) cycle();
        cpu_memEn = 1'b1;
        cycle();
        cpu_memEn = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_wr_ptr", wr_ptr, 0);
        chk("arst_rd_ptr", rd_ptr, 0);
        chk("arst_count", pkt_count, 0);
        chk("arst_busy", dma_busy, 0);
        chk("arst_no_mem", mem_memEn, 0);
        #1;
        reset = 1'b1;
        model_clear();

        // 19 packets, no pops: mailbox fills and wraps
        dma_en = 1'b1;
        for (int i = 0; i < 19; i++) add_pkt(64'hA000_0000_0000_0000 | 64'(i));
        repeat (300) cycle();
        chk("full_count", pkt_count, 16);
        chk("full_wr_wrap", wr_ptr, 0);
`ifdef NIC_DMA_DROP_CNT_EN
        chk("full_drop3", drop_count, 3);
        chk("full_nic_drained", nic_q.size(), 0);
`else
        chk("full_nic_held", nic_q.size(), 3);
`endif
        dma_pop = 1'b1;
        cycle();
        dma_pop = 1'b0;
        repeat (20) cycle();
        chk("pop_rd_ptr", rd_ptr, 1);
`ifdef NIC_DMA_DROP_CNT_EN
        chk("pop_count", pkt_count, 15);
        chk("pop_wr_ptr", wr_ptr, 0);
`else
        chk("pop_count", pkt_count, 16);
        chk("pop_wr_ptr", wr_ptr, 1);
`endif

        // simultaneous push and pop at count 5
        do_reset();
        dma_en = 1'b1;
        for (int i = 0; i < 5; i++) add_pkt(64'hB000_0000_0000_0000 | 64'(i));
        repeat (40) cycle();
        chk("t5_pre_count", pkt_count, 5);
        settle_idle();
        dma_en = 1'b1;
        add_pkt(64'hB000_0000_0000_0005);
        repeat (3) cycle();
        dma_pop = 1'b1; wr_seen = 0;
        cycle();
        dma_pop = 1'b0;
        chk("t5_wr_seen", wr_seen, 1);
        chk("t5_count", pkt_count, 5);
        chk("t5_wr_ptr", wr_ptr, 6);
        chk("t5_rd_ptr", rd_ptr, 1);

        // randomized contention, light then heavy consumption
        do_reset();
        rnd = 1;
        pop_pct = 8;
        repeat (800) cycle();
        pop_pct = 50;
        repeat (800) cycle();
        rnd = 0;
        cpu_memEn = 1'b0; cpu_nicEn = 1'b0; dma_en = 1'b1; dma_pop = 1'b1;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            cycle();
            done = nic_q.size() == 0 && pend.size() == 0 && m_count == 0;
        end
        dma_pop = 1'b0;
        chk("drain_done", done, 1);
        chk("all_accounted", m_total + m_drop, gen_total);
        repeat (3) cycle();
        chk("drain_count", pkt_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
